lsu_multicycle: RTL and testbench

Parametrised multi-cycle load/store unit that replaces the single-cycle combinational main-memory access path of the core.
- Accepts one load/store request from the control path and computes the effective address.
- Checks alignment, drives a variable-latency memory bus with byte strobes, and returns sign- or zero-extended load data for register writeback.
- Supports all RV32 (and RV64 when XLEN=64) load/store widths, with bus timeout and error reporting.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 74 +++++++
 rtl/lsu_multicycle.sv | 147 ++++++++++++++
 tb/tb_lsu_multicycle.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the multi-cycle load/store unit: funct3 codes,
// response error codes and the controller state encoding.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store strobes/data shift, load extraction with
// sign/zero extension, and the funct3 legality and alignment checks.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign,
  output logic              illegal
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);

  logic [1:0]        sz;
  logic [LANE_W-1:0] off;
  logic [NB-1:0]     strb_raw;
  logic [XLEN-1:0]   byte_mask;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   tmp;
  int                nbits;

  assign sz  = funct3[1:0];
  assign off = addr_lo[LANE_W-1:0];

  always_comb begin
    strb_raw  = '0;
    byte_mask = '0;
    for (int i = 0; i < NB; i++) begin
      strb_raw[i]        = (i < (1 << sz));
      byte_mask[8*i +: 8] = {8{strb_raw[i]}};
    end
    wstrb = strb_raw << off;
    wdata = (store_data & byte_mask) << (8 * off);
  end

  // Extension by shifting the field to the MSB and back; the if/else keeps
  // the arithmetic shift out of an unsigned expression context.
  always_comb begin
    sh        = rdata >> (8 * off);
    nbits     = 8 << sz;
    tmp       = '0;
    load_data = sh;
    if (nbits < XLEN) begin
      tmp = sh << (XLEN - nbits);
      if (funct3[2]) load_data = tmp >> (XLEN - nbits);
      else           load_data = $unsigned($signed(tmp) >>> (XLEN - nbits));
    end
  end

  always_comb begin
    misalign = 1'b0;
    case (sz)
      2'd1:    misalign = addr_lo[0];
      2'd2:    misalign = |addr_lo[1:0];
      2'd3:    misalign = |addr_lo[2:0];
      default: misalign = 1'b0;
    endcase
    if (is_store)
      illegal = !(funct3 inside {SB, SH, SW} || (XLEN == 64 && funct3 == SD));
    else
      illegal = !(funct3 inside {LB, LH, LW, LBU, LHU} ||
                  (XLEN == 64 && funct3 inside {LD, LWU}));
  end

endmodule

// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: accepts one request, runs a single bus
// transaction with timeout, and holds the response until it is consumed.
//
// state   | meaning
// ST_IDLE | ready for a request; decode and checks use the live request
// ST_BUS  | mem_req asserted, waiting for mem_ack or timeout
// ST_RESP | resp_valid asserted, waiting for resp_ready
module lsu_multicycle
  import lsu_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_offset,
  input  logic [XLEN-1:0]   req_store_data,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;

  lsu_state_t        state, state_n;
  logic [XLEN-1:0]   eff;
  logic [ADDR_W-1:0] eff_addr;
  logic [2:0]        f3_q;
  logic              is_store_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, resp_data_q;
  logic [NB-1:0]     strb_q;
  logic [1:0]        err_q;
  logic [31:0]       cnt;
  logic              idle, expire;

  logic [2:0]        al_f3, al_lo;
  logic              al_store, al_misalign, al_illegal;
  logic [NB-1:0]     al_wstrb;
  logic [XLEN-1:0]   al_wdata, al_load;

  assign eff      = req_base + req_offset;
  assign eff_addr = ADDR_W'(eff);
  assign idle     = (state == ST_IDLE);
  assign expire   = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

  // The single aligner sees the live request while idle and the captured
  // request afterwards, so load extraction uses the accepted funct3/offset.
  assign al_f3    = idle ? req_funct3   : f3_q;
  assign al_store = idle ? req_is_store : is_store_q;
  assign al_lo    = idle ? eff[2:0]     : addr_q[2:0];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_f3),
    .is_store   (al_store),
    .addr_lo    (al_lo),
    .store_data (req_store_data),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req_valid) state_n = (al_illegal || al_misalign) ? ST_RESP : ST_BUS;
      ST_BUS:  if (mem_ack || expire) state_n = ST_RESP;
      ST_RESP: if (resp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      f3_q        <= '0;
      is_store_q  <= 1'b0;
      rd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      resp_data_q <= '0;
      err_q       <= ERR_OK;
      cnt         <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (req_valid) begin
          f3_q        <= req_funct3;
          is_store_q  <= req_is_store;
          rd_q        <= req_rd;
          addr_q      <= eff_addr;
          wdata_q     <= al_wdata;
          strb_q      <= al_wstrb;
          cnt         <= '0;
          resp_data_q <= '0;
          err_q       <= al_illegal  ? ERR_ILLEGAL  :
                         al_misalign ? ERR_MISALIGN : ERR_OK;
        end
        ST_BUS: begin
          if (mem_ack) begin
            resp_data_q <= is_store_q ? '0 : al_load;
            err_q       <= ERR_OK;
          end else if (expire) begin
            resp_data_q <= '0;
            err_q       <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state == ST_RESP);
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign mem_req    = (state == ST_BUS);
  assign mem_we     = mem_req & is_store_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = mem_req ? strb_q : '0;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Directed bench for lsu_multicycle (XLEN=32, TIMEOUT=8) with hand-computed
// expected bus fields, load extension results and error codes.
module tb_lsu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] base,
                      input logic [31:0] off, input logic [31:0] sdata, input logic [4:0] rd);
    req_is_store   = st;
    req_funct3     = f3;
    req_base       = base;
    req_offset     = off;
    req_store_data = sdata;
    req_rd         = rd;
    req_valid      = 1'b1;
    tick();
    req_valid      = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ":req_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, ":resp_valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  // k bus cycles without ack, then ack on the next one.
  task automatic bus_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] sdata, input logic [4:0] rd, input int k,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_data);
    send(st, f3, base, off, sdata, rd);
    check({tag, ":mem_addr"}, mem_addr, exp_addr);
    check({tag, ":mem_we"}, 32'(mem_we), 32'(st));
    if (st) begin
      check({tag, ":mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
      check({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
    end
    for (int i = 0; i < k; i++) begin
      check({tag, ":mem_req"}, 32'(mem_req), 32'd1);
      check({tag, ":resp_early"}, 32'(resp_valid), 32'd0);
      tick();
    end
    check({tag, ":mem_req_ack"}, 32'(mem_req), 32'd1);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
    check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ":mem_req_drop"}, 32'(mem_req), 32'd0);
    check({tag, ":resp_err"}, 32'(resp_err), 32'd0);
    check({tag, ":resp_data"}, resp_data, exp_data);
    check({tag, ":resp_rd"}, 32'(resp_rd), 32'(rd));
  endtask

  task automatic err_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [4:0] rd, input logic [1:0] exp_err);
    send(st, f3, base, off, 32'hFFFF_FFFF, rd);
    check({tag, ":no_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ":resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ":resp_data"}, resp_data, 32'd0);
    check({tag, ":resp_rd"}, 32'(resp_rd), 32'(rd));
    finish_resp(tag);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_offset = '0; req_store_data = '0; req_rd = '0;
    resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst:resp_err", 32'(resp_err), 32'd0);
    check("rst:resp_data", resp_data, 32'd0);
    rst = 1'b0;
    tick();

    bus_txn("sw", 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEAD_BEEF, 5'd1, 3,
            32'hFFFF_FFFF, 32'h104, 4'hF, 32'hDEAD_BEEF, 32'h0);
    finish_resp("sw");
    bus_txn("lb", 1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd2, 1,
            32'h80FF_1234, 32'h203, 4'h0, 32'h0, 32'hFFFF_FF80);
    finish_resp("lb");
    bus_txn("lbu", 1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd3, 0,
            32'h80FF_1234, 32'h203, 4'h0, 32'h0, 32'h0000_0080);
    finish_resp("lbu");
    bus_txn("sb", 1'b1, 3'b000, 32'h200, 32'h3, 32'h1234_565A, 5'd4, 2,
            32'h0, 32'h203, 4'h8, 32'h5A00_0000, 32'h0);
    finish_resp("sb");
    bus_txn("lh", 1'b0, 3'b001, 32'h100, 32'h2, 32'h0, 5'd5, 1,
            32'h8001_1234, 32'h102, 4'h0, 32'h0, 32'hFFFF_8001);
    finish_resp("lh");
    bus_txn("lhu", 1'b0, 3'b101, 32'h100, 32'h2, 32'h0, 5'd6, 0,
            32'h8001_1234, 32'h102, 4'h0, 32'h0, 32'h0000_8001);
    finish_resp("lhu");
    bus_txn("sh", 1'b1, 3'b001, 32'h100, 32'h2, 32'h9999_ABCD, 5'd7, 1,
            32'h0, 32'h102, 4'hC, 32'hABCD_0000, 32'h0);
    finish_resp("sh");
    bus_txn("lw_wrap", 1'b0, 3'b010, 32'h200, 32'hFFFF_FFFC, 32'h0, 5'd8, 0,
            32'h1234_5678, 32'h1FC, 4'h0, 32'h0, 32'h1234_5678);
    finish_resp("lw_wrap");

    err_txn("lw_mis", 1'b0, 3'b010, 32'h100, 32'h1, 5'd10, 2'd1);
    err_txn("ld_rv32", 1'b0, 3'b011, 32'h100, 32'h0, 5'd11, 2'd2);
    err_txn("ill_and_mis", 1'b0, 3'b011, 32'h100, 32'h1, 5'd12, 2'd2);
    err_txn("st_f3_4", 1'b1, 3'b100, 32'h100, 32'h0, 5'd13, 2'd2);
    err_txn("sh_mis", 1'b1, 3'b001, 32'h101, 32'h0, 5'd14, 2'd1);

    send(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd15);
    for (int i = 0; i < 8; i++) begin
      check("to:mem_req", 32'(mem_req), 32'd1);
      tick();
    end
    check("to:mem_req_drop", 32'(mem_req), 32'd0);
    check("to:resp_valid", 32'(resp_valid), 32'd1);
    check("to:resp_err", 32'(resp_err), 32'd3);
    check("to:resp_data", resp_data, 32'd0);
    finish_resp("to");
    bus_txn("ack8", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd16, 7,
            32'hCAFE_F00D, 32'h300, 4'h0, 32'h0, 32'hCAFE_F00D);
    finish_resp("ack8");

    bus_txn("hold", 1'b0, 3'b100, 32'h200, 32'h1, 32'h0, 5'd9, 1,
            32'h0000_C300, 32'h201, 4'h0, 32'h0, 32'h0000_00C3);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h400;
    req_offset = 32'h0; req_rd = 5'd20; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold:resp_valid", 32'(resp_valid), 32'd1);
      check("hold:resp_data", resp_data, 32'h0000_00C3);
      check("hold:resp_rd", 32'(resp_rd), 32'd9);
      check("hold:resp_err", 32'(resp_err), 32'd0);
      check("hold:req_ready", 32'(req_ready), 32'd0);
      check("hold:mem_req", 32'(mem_req), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    finish_resp("hold");
    tick();
    check("hold:ignored_req", 32'(mem_req), 32'd0);

    send(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 5'd21);
    check("rstbus:mem_req", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstbus:mem_req_drop", 32'(mem_req), 32'd0);
    check("rstbus:req_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    check("rstbus:late_ack", 32'(resp_valid), 32'd0);
    check("rstbus:mem_req_idle", 32'(mem_req), 32'd0);
    tick();
    check("rstbus:still_idle", 32'(resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
